hs_npu_job_sequencer: RTL and testbench

Memory-ordering-side responder to the executive's start handshake. Accepts one layer job per valid/ready transfer and latches the layer configuration. Streams word read requests for inputs then weights, triggers the systolic array, streams results back to memory, then pulses finished, which drives the executive's irq and INIT clear.

---
 rtl/hs_npu_job_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_hs_npu_job_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_npu_job_sequencer.sv
// Layer job sequencer: accepts a job, streams input/weight reads, kicks the array, writes results back.
// Optional HS_NPU_SEQ_DIMCHK_EN adds an input-columns == weight-rows compatibility check.
module hs_npu_job_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              finished_o,
  output logic              error_o,
  input  logic [31:0]       num_input_rows_i,
  input  logic [31:0]       num_input_columns_i,
  input  logic [31:0]       num_weight_rows_i,
  input  logic [31:0]       num_weight_columns_i,
  input  logic              reuse_inputs_i,
  input  logic              reuse_weights_i,
  input  logic              save_outputs_i,
  input  logic [ADDR_W-1:0] base_address_i,
  input  logic [ADDR_W-1:0] result_address_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [ADDR_W-1:0] mem_req_wdata_o,
  output logic              compute_start_o,
  input  logic              compute_done_i,
  input  logic              res_valid_i,
  input  logic [ADDR_W-1:0] res_data_i,
  output logic              res_ready_o
);

  localparam int PW = 2 * DIM_W + 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, LOAD_IN, LOAD_W, START, COMPUTE, STORE, DONE
  } state_t;

  state_t            state_reg;
  logic [DIM_W-1:0]  in_rows_reg, in_cols_reg, w_rows_reg, w_cols_reg;
  logic              reuse_in_reg, reuse_w_reg, save_reg, error_reg;
  logic [ADDR_W-1:0] base_reg, result_reg, addr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  in_words, w_words, out_words, phase_words;
  logic [ADDR_W-1:0] w_base;
  logic              dims_bad, mem_fire, last_word;
  logic              unused_dim_bits;

  // Packed int8: four elements per word, rounded up.
  function automatic logic [CNT_W-1:0] word_count(input logic [DIM_W-1:0] a,
                                                  input logic [DIM_W-1:0] b);
    logic [PW-1:0] prod;
    prod = PW'(a) * PW'(b) + PW'(3);
    return CNT_W'(prod >> 2);
  endfunction

  assign in_words  = word_count(in_rows_reg, in_cols_reg);
  assign w_words   = word_count(w_rows_reg, w_cols_reg);
  assign out_words = word_count(in_rows_reg, w_cols_reg);
  // Weights always follow the full input block, even when inputs are reused.
  assign w_base    = base_reg + ADDR_W'({in_words, 2'b00});

  assign unused_dim_bits = ^{num_input_rows_i[31:DIM_W], num_input_columns_i[31:DIM_W],
                             num_weight_rows_i[31:DIM_W], num_weight_columns_i[31:DIM_W]};

`ifdef HS_NPU_SEQ_DIMCHK_EN
  assign dims_bad = (in_rows_reg == '0) || (in_cols_reg == '0) || (w_rows_reg == '0) ||
                    (w_cols_reg == '0) || (in_cols_reg != w_rows_reg);
`else
  assign dims_bad = (in_rows_reg == '0) || (in_cols_reg == '0) || (w_rows_reg == '0) ||
                    (w_cols_reg == '0);
`endif

  assign ready_o         = (state_reg == IDLE);
  assign finished_o      = (state_reg == DONE);
  assign error_o         = (state_reg == DONE) && error_reg;
  assign compute_start_o = (state_reg == START);
  // Valid depends only on state (and res_valid_i while storing), never on mem_req_ready_i.
  assign mem_req_valid_o = (state_reg == LOAD_IN) || (state_reg == LOAD_W) ||
                           ((state_reg == STORE) && res_valid_i);
  assign mem_req_we_o    = (state_reg == STORE);
  assign mem_req_addr_o  = addr_reg;
  assign mem_req_wdata_o = (state_reg == STORE) ? res_data_i : '0;
  assign res_ready_o     = (state_reg == STORE) && res_valid_i && mem_req_ready_i;
  assign mem_fire        = mem_req_valid_o && mem_req_ready_i;

  always_comb begin
    phase_words = out_words;
    if (state_reg == LOAD_IN) phase_words = in_words;
    else if (state_reg == LOAD_W) phase_words = w_words;
  end
  assign last_word = (cnt_reg == phase_words - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      in_rows_reg  <= '0;
      in_cols_reg  <= '0;
      w_rows_reg   <= '0;
      w_cols_reg   <= '0;
      reuse_in_reg <= 1'b0;
      reuse_w_reg  <= 1'b0;
      save_reg     <= 1'b0;
      error_reg    <= 1'b0;
      base_reg     <= '0;
      result_reg   <= '0;
      addr_reg     <= '0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            in_rows_reg  <= num_input_rows_i[DIM_W-1:0];
            in_cols_reg  <= num_input_columns_i[DIM_W-1:0];
            w_rows_reg   <= num_weight_rows_i[DIM_W-1:0];
            w_cols_reg   <= num_weight_columns_i[DIM_W-1:0];
            reuse_in_reg <= reuse_inputs_i;
            reuse_w_reg  <= reuse_weights_i;
            save_reg     <= save_outputs_i;
            base_reg     <= base_address_i;
            result_reg   <= result_address_i;
            error_reg    <= 1'b0;
            state_reg    <= CHECK;
          end
        end
        CHECK: begin
          cnt_reg <= '0;
          if (dims_bad) begin
            error_reg <= 1'b1;
            state_reg <= DONE;
          end else if (!reuse_in_reg) begin
            addr_reg  <= base_reg;
            state_reg <= LOAD_IN;
          end else if (!reuse_w_reg) begin
            addr_reg  <= w_base;
            state_reg <= LOAD_W;
          end else begin
            state_reg <= START;
          end
        end
        LOAD_IN: begin
          if (mem_fire) begin
            if (last_word) begin
              cnt_reg <= '0;
              if (!reuse_w_reg) begin
                addr_reg  <= w_base;
                state_reg <= LOAD_W;
              end else begin
                state_reg <= START;
              end
            end else begin
              cnt_reg  <= cnt_reg + CNT_W'(1);
              addr_reg <= addr_reg + ADDR_W'(4);
            end
          end
        end
        LOAD_W: begin
          if (mem_fire) begin
            if (last_word) begin
              cnt_reg   <= '0;
              state_reg <= START;
            end else begin
              cnt_reg  <= cnt_reg + CNT_W'(1);
              addr_reg <= addr_reg + ADDR_W'(4);
            end
          end
        end
        START: state_reg <= COMPUTE;
        COMPUTE: begin
          if (compute_done_i) begin
            if (save_reg) begin
              cnt_reg   <= '0;
              addr_reg  <= result_reg;
              state_reg <= STORE;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        STORE: begin
          if (mem_fire) begin
            if (last_word) begin
              cnt_reg   <= '0;
              state_reg <= DONE;
            end else begin
              cnt_reg  <= cnt_reg + CNT_W'(1);
              addr_reg <= addr_reg + ADDR_W'(4);
            end
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_npu_job_sequencer.sv
// Self-checking bench: directed and random jobs compared against a transaction-list reference model.
module tb_hs_npu_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o, finished_o, error_o;
  logic [31:0] num_input_rows_i = '0, num_input_columns_i = '0;
  logic [31:0] num_weight_rows_i = '0, num_weight_columns_i = '0;
  logic        reuse_inputs_i = 1'b0, reuse_weights_i = 1'b0, save_outputs_i = 1'b0;
  logic [31:0] base_address_i = '0, result_address_i = '0;
  logic        mem_req_valid_o, mem_req_we_o;
  logic        mem_req_ready_i = 1'b1;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic        compute_start_o;
  logic        compute_done_i = 1'b0;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_data_i = '0;
  logic        res_ready_o;

  always #5 clk = ~clk;

  hs_npu_job_sequencer dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .finished_o(finished_o), .error_o(error_o),
    .num_input_rows_i(num_input_rows_i), .num_input_columns_i(num_input_columns_i),
    .num_weight_rows_i(num_weight_rows_i), .num_weight_columns_i(num_weight_columns_i),
    .reuse_inputs_i(reuse_inputs_i), .reuse_weights_i(reuse_weights_i),
    .save_outputs_i(save_outputs_i), .base_address_i(base_address_i),
    .result_address_i(result_address_i), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
    .compute_start_o(compute_start_o), .compute_done_i(compute_done_i),
    .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_ready_o(res_ready_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment knobs and observed transactions
  int          ready_mode = 0;   // 0 always ready, 1 random, 2 pattern 1-0-0-1
  int          pat_idx = 0;
  int          done_delay = 0;   // 0 -> random 1..5
  int          done_timer = 0;
  bit          spurious = 1'b0;
  int          res_idx = 0;
  logic [31:0] salt = '0;
  bit          took_n = 1'b0;
  int          cyc = 0, acc_cyc = 0, start_cyc = 0, fin_cyc = 0;
  int          starts = 0, fin_cnt = 0;
  logic        fin_err = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;
  logic        stall_we = 1'b0;
  logic [31:0] got_addr[$], got_data[$];
  logic        got_we[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_we[$];
  logic        exp_err;
  int          exp_starts;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: mem_req_ready_i = 1'b1;
      1: mem_req_ready_i = 1'($urandom_range(0, 1));
      default: mem_req_ready_i = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
    endcase
    pat_idx++;
  end

  // Result source: holds a word until the sequencer consumes it
  always @(posedge clk) begin
    #1;
    if (took_n) res_idx++;
    if (!res_valid_i || took_n) res_valid_i = ($urandom_range(0, 3) != 0);
    res_data_i = salt + 32'(res_idx);
  end

  always @(posedge clk) begin
    #1;
    compute_done_i = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) compute_done_i = 1'b1;
    end else if (spurious && $urandom_range(0, 9) == 0) begin
      compute_done_i = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    took_n = 1'b0;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(mem_req_valid_o), 64'd1);
        check("hold_addr", 64'(mem_req_addr_o), 64'(stall_addr));
        check("hold_we", 64'(mem_req_we_o), 64'(stall_we));
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        got_addr.push_back(mem_req_addr_o);
        got_we.push_back(mem_req_we_o);
        got_data.push_back(mem_req_wdata_o);
      end
      stall_prev = mem_req_valid_o && !mem_req_ready_i;
      stall_addr = mem_req_addr_o;
      stall_we   = mem_req_we_o;
      if (compute_start_o) begin
        starts++;
        start_cyc  = cyc;
        done_timer = (done_delay > 0) ? done_delay : $urandom_range(1, 5);
      end
      if (finished_o) begin
        fin_cnt++;
        fin_err = error_o;
        fin_cyc = cyc;
      end
      if (valid_i && ready_o) acc_cyc = cyc;
      took_n = res_valid_i && res_ready_o;
    end
  end

  // Reference model: the full list of memory transactions a job must produce
  task automatic build_expect(input logic [31:0] ri_, ci_, rw_, cw_, input bit rin, rwt, sv,
                              input logic [31:0] base, res);
    int ri, ci, rw, cw, inw, ww, ow;
    ri = int'(ri_ & 32'hFF); ci = int'(ci_ & 32'hFF);
    rw = int'(rw_ & 32'hFF); cw = int'(cw_ & 32'hFF);
    exp_err = (ri == 0) || (ci == 0) || (rw == 0) || (cw == 0);
`ifdef HS_NPU_SEQ_DIMCHK_EN
    if (ci != rw) exp_err = 1'b1;
`endif
    inw = (ri * ci + 3) / 4;
    ww  = (rw * cw + 3) / 4;
    ow  = (ri * cw + 3) / 4;
    exp_addr.delete(); exp_we.delete(); exp_data.delete();
    exp_starts = exp_err ? 0 : 1;
    if (!exp_err) begin
      if (!rin) for (int k = 0; k < inw; k++) begin
        exp_addr.push_back(base + 32'(4 * k)); exp_we.push_back(1'b0); exp_data.push_back('0);
      end
      if (!rwt) for (int k = 0; k < ww; k++) begin
        exp_addr.push_back(base + 32'(4 * inw) + 32'(4 * k));
        exp_we.push_back(1'b0); exp_data.push_back('0);
      end
      if (sv) for (int k = 0; k < ow; k++) begin
        exp_addr.push_back(res + 32'(4 * k)); exp_we.push_back(1'b1);
        exp_data.push_back(salt + 32'(k));
      end
    end
  endtask

  task automatic start_job(input logic [31:0] ri, ci, rw, cw, input bit rin, rwt, sv,
                           input logic [31:0] base, res);
    got_addr.delete(); got_we.delete(); got_data.delete();
    fin_cnt = 0; starts = 0; res_idx = 0; done_timer = 0;
    salt = $urandom;
    build_expect(ri, ci, rw, cw, rin, rwt, sv, base, res);
    @(posedge clk); #1;
    check("ready_idle", 64'(ready_o), 64'd1);
    num_input_rows_i = ri; num_input_columns_i = ci;
    num_weight_rows_i = rw; num_weight_columns_i = cw;
    reuse_inputs_i = rin; reuse_weights_i = rwt; save_outputs_i = sv;
    base_address_i = base; result_address_i = res;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    // Scramble the config bus: the sequencer must work from its latched copy
    num_input_rows_i = $urandom; num_input_columns_i = $urandom;
    num_weight_rows_i = $urandom; num_weight_columns_i = $urandom;
    base_address_i = $urandom; result_address_i = $urandom;
    reuse_inputs_i = 1'($urandom); reuse_weights_i = 1'($urandom);
    save_outputs_i = 1'($urandom);
    check("ready_busy", 64'(ready_o), 64'd0);
  endtask

  task automatic finish_job(input string tag);
    int n;
    int m;
    n = 0;
    while (fin_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_finish_seen"}, 64'(fin_cnt > 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_finish_once"}, 64'(fin_cnt), 64'd1);
    check({tag, "_error"}, 64'(fin_err), 64'(exp_err));
    check({tag, "_starts"}, 64'(starts), 64'(exp_starts));
    check({tag, "_nreq"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_we%0d", tag, i), 64'(got_we[i]), 64'(exp_we[i]));
      if (exp_we[i]) check($sformatf("%s_wdata%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
    end
    $display("job %s: %0d requests, error=%0b, starts=%0d", tag, got_addr.size(), fin_err, starts);
    if (fin_cnt == 0) begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, d1, d2, d3;
    int n;
    #12;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_finished", 64'(finished_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_start", 64'(compute_start_o), 64'd0);
    check("rst_addr", 64'(mem_req_addr_o), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    start_job(4, 4, 4, 4, 0, 0, 1, 32'h1000, 32'h2000);
    finish_job("basic4x4");

    start_job(3, 5, 5, 2, 1, 0, 1, 32'h0000_4000, 32'h0000_8000);
    finish_job("reuse_in");

    ready_mode = 2;
    start_job(3, 3, 3, 3, 0, 0, 1, 32'h3000, 32'h5000);
    finish_job("stall_pat");
    ready_mode = 0;

    start_job(4, 4, 4, 0, 0, 0, 1, 32'h1000, 32'h2000);
    finish_job("zero_dim");

    start_job(4, 3, 4, 4, 0, 0, 1, 32'h6000, 32'h7000);
    finish_job("dimchk");

    // All reuse, no save: fixed compute time of one cycle
    done_delay = 1;
    start_job(2, 2, 2, 2, 1, 1, 0, 32'h100, 32'h200);
    finish_job("latency");
    check("latency_start", 64'(start_cyc - acc_cyc), 64'd2);
    check("latency_fin", 64'(fin_cyc - acc_cyc), 64'd4);
    done_delay = 0;

    start_job(32'hABCD_0102, 32'h0000_0303, 32'hFF00_0003, 32'h1234_5602, 0, 0, 1,
              32'h9000, 32'hA000);
    finish_job("upper_bits");

    start_job(3, 3, 2, 3, 0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    finish_job("wrap");

    // Asynchronous reset while weights are being fetched
    start_job(4, 4, 4, 4, 0, 0, 1, 32'h1000, 32'h2000);
    n = 0;
    while (got_addr.size() < 6 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("rst_mid_reached_loadw", 64'(got_addr.size() >= 6), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd1);
    check("rst_mid_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_mid_addr", 64'(mem_req_addr_o), 64'd0);
    check("rst_mid_we", 64'(mem_req_we_o), 64'd0);
    check("rst_mid_finished", 64'(finished_o), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_finish", 64'(fin_cnt), 64'd0);
    check("rst_mid_ready_after", 64'(ready_o), 64'd1);
    $display("job rst_mid: reset applied during weight fetch");
    start_job(2, 4, 4, 3, 0, 0, 1, 32'h1000, 32'h2000);
    finish_job("after_rst");

    ready_mode = 1;
    spurious = 1'b1;
    for (int j = 0; j < 20; j++) begin
      d0 = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
      d1 = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
      d2 = ($urandom_range(0, 3) == 0) ? d1 : 32'($urandom_range(1, 9));
      d3 = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
      d0 = d0 | ($urandom & 32'hFFFF_FF00);
      start_job(d0, d1, d2, d3, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
      finish_job($sformatf("rand%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
